// File: rtl/ema_channel_scheduler.sv
// Round-robin scheduler sharing one EMA unit (acc += x - acc/2^K) across NCH channels; result 2 cycles after grant.
// Optional EMA_SCHED_PRELOAD_EN: the first sample after reset/clear seeds the channel output directly.
module ema_channel_scheduler #(
  parameter int NCH   = 4,
  parameter int WIDTH = 16,
  parameter int K     = 3
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NCH-1:0]                         req_valid,
  input  logic [NCH*WIDTH-1:0]                   req_sample,
  output logic [NCH-1:0]                         req_ready,
  input  logic [NCH-1:0]                         clr,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic signed [WIDTH-1:0]                out_sample,
  output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] out_ch
);

  localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int ACCW = WIDTH + K + 1;

  typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

  state_t                  state_q, state_d;
  logic [CHW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [CHW-1:0]          ch_q, ch_d;
  logic signed [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0]        out_sample_q, out_sample_d;
  logic signed [ACCW-1:0]  acc_q [NCH];
  logic signed [ACCW-1:0]  acc_d [NCH];

  logic                    grant_vld;
  logic                    grant_fire;
  logic [CHW-1:0]          grant_ch;
  logic [NCH-1:0]          grant_oh;

  logic signed [ACCW-1:0]  acc_cur;
  logic signed [ACCW-1:0]  x_ext;
  logic signed [ACCW-1:0]  acc_shr;
  logic signed [ACCW-1:0]  acc_new;

`ifdef EMA_SCHED_PRELOAD_EN
  logic [NCH-1:0]          primed_q, primed_d;
`endif

  // First requester at or after rr_ptr, wrapping modulo NCH.
  always_comb begin
    logic [CHW:0] sum;
    grant_vld = 1'b0;
    grant_ch  = '0;
    sum       = '0;
    for (int i = 0; i < NCH; i++) begin
      sum = {1'b0, rr_ptr_q} + (CHW+1)'(i);
      if (sum >= (CHW+1)'(NCH)) sum = sum - (CHW+1)'(NCH);
      if (!grant_vld && req_valid[sum[CHW-1:0]]) begin
        grant_vld = 1'b1;
        grant_ch  = sum[CHW-1:0];
      end
    end
    grant_oh = '0;
    if (grant_vld) grant_oh[grant_ch] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_vld) state_d = CALC;
      CALC:    state_d = OUT;
      OUT:     if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = '0;
    out_valid  = 1'b0;
    grant_fire = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready  = rst ? '0 : grant_oh;
        grant_fire = grant_vld && !rst;
      end
      OUT:     out_valid = 1'b1;
      default: ;
    endcase
  end

  // Shift operand kept in its own signed variable so >>> stays arithmetic.
  always_comb begin
    acc_cur = acc_q[ch_q];
    x_ext   = {{(K+1){x_q[WIDTH-1]}}, x_q};
    acc_shr = acc_cur >>> K;
    acc_new = acc_cur + x_ext - acc_shr;
`ifdef EMA_SCHED_PRELOAD_EN
    if (!primed_q[ch_q]) acc_new = x_ext <<< K;
`endif
  end

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    ch_d         = ch_q;
    x_d          = x_q;
    out_sample_d = out_sample_q;
    acc_d        = acc_q;
`ifdef EMA_SCHED_PRELOAD_EN
    primed_d     = primed_q;
`endif
    if (grant_fire) begin
      rr_ptr_d = (grant_ch == CHW'(NCH-1)) ? '0 : grant_ch + 1'b1;
      ch_d     = grant_ch;
      x_d      = req_sample[grant_ch*WIDTH +: WIDTH];
    end
    if (state_q == CALC) begin
      acc_d[ch_q]  = acc_new;
      out_sample_d = acc_new[K+WIDTH-1:K];
`ifdef EMA_SCHED_PRELOAD_EN
      primed_d[ch_q] = 1'b1;
`endif
    end
    // A clear landing on the channel being updated wins over the write-back.
    for (int c = 0; c < NCH; c++) begin
      if (clr[c]) begin
        acc_d[c] = '0;
`ifdef EMA_SCHED_PRELOAD_EN
        primed_d[c] = 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q     <= '0;
      ch_q         <= '0;
      x_q          <= '0;
      out_sample_q <= '0;
      for (int c = 0; c < NCH; c++) acc_q[c] <= '0;
`ifdef EMA_SCHED_PRELOAD_EN
      primed_q     <= '0;
`endif
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      ch_q         <= ch_d;
      x_q          <= x_d;
      out_sample_q <= out_sample_d;
      for (int c = 0; c < NCH; c++) acc_q[c] <= acc_d[c];
`ifdef EMA_SCHED_PRELOAD_EN
      primed_q     <= primed_d;
`endif
    end
  end

  assign out_sample = out_sample_q;
  assign out_ch     = ch_q;

endmodule

// File: tb/tb_ema_channel_scheduler.sv
// Bench for ema_channel_scheduler: directed scenarios plus random traffic against a transaction-level EMA model.
module tb_ema_channel_scheduler;

  localparam int NCH   = 4;
  localparam int WIDTH = 16;
  localparam int K     = 3;
  localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1;
`ifdef EMA_SCHED_PRELOAD_EN
  localparam bit PRELOAD = 1'b1;
`else
  localparam bit PRELOAD = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [NCH-1:0]          vld = '0;
  logic [NCH-1:0]          clr_v = '0;
  logic signed [WIDTH-1:0] smp [NCH];
  logic [NCH*WIDTH-1:0]    req_sample;
  logic [NCH-1:0]          req_ready;
  logic                    out_valid;
  logic                    out_ready = 1'b0;
  logic signed [WIDTH-1:0] out_sample;
  logic [CHW-1:0]          out_ch;

  always #5 clk = ~clk;

  always_comb begin
    req_sample = '0;
    for (int c = 0; c < NCH; c++) req_sample[c*WIDTH +: WIDTH] = smp[c];
  end

  ema_channel_scheduler #(.NCH(NCH), .WIDTH(WIDTH), .K(K)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (vld),
    .req_sample (req_sample),
    .req_ready  (req_ready),
    .clr        (clr_v),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sample (out_sample),
    .out_ch     (out_ch)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: y scaled by 2^K per channel, floor semantics for the divide.
  longint         macc [NCH];
  bit             mprimed [NCH];
  int             mptr = 0;
  int             phase = 0;
  int             gch = 0;
  longint         gx = 0;
  longint         exp_out = 0;
  int             mg;
  logic [NCH-1:0] m_exp_rdy;
  logic [NCH-1:0] strobe_seen = '0;
  logic [NCH-1:0] last_gnt = '0;
  bit             auto_rearm = 1'b0;
  int             gnt_q [$];
  longint         out_q [$];

  function automatic longint fdiv(input longint a);
    longint d = longint'(1) << K;
    longint q = a / d;
    if (a < 0 && (a % d) != 0) q = q - 1;
    return q;
  endfunction

  function automatic longint ema_next(input longint acc, input longint x, input bit primed);
    if (PRELOAD && !primed) return x * (longint'(1) << K);
    return acc + x - fdiv(acc);
  endfunction

  function automatic logic signed [WIDTH-1:0] rnd_sample();
    return WIDTH'($urandom);
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      check_eq("rdy_in_rst", req_ready, 0);
      for (int c = 0; c < NCH; c++) begin
        macc[c]    = 0;
        mprimed[c] = 1'b0;
      end
      mptr        = 0;
      phase       = 0;
      strobe_seen = '0;
    end else begin
      mg        = -1;
      m_exp_rdy = '0;
      if (phase == 0)
        for (int i = 0; i < NCH; i++)
          if (mg < 0 && vld[(mptr + i) % NCH]) mg = (mptr + i) % NCH;
      if (mg >= 0) m_exp_rdy[mg] = 1'b1;
      check_eq("req_ready", req_ready, m_exp_rdy);
      check_eq("out_valid", out_valid, (phase == 2) ? 1 : 0);
      if (phase == 2) begin
        check_eq("out_sample", out_sample, exp_out);
        check_eq("out_ch", out_ch, gch);
      end
      strobe_seen = req_ready;
      for (int c = 0; c < NCH; c++) if (req_ready[c]) gnt_q.push_back(c);
      case (phase)
        0: if (mg >= 0) begin
          gch   = mg;
          gx    = smp[mg];
          mptr  = (mg + 1) % NCH;
          phase = 1;
        end
        1: begin
          macc[gch]    = ema_next(macc[gch], gx, mprimed[gch]);
          mprimed[gch] = 1'b1;
          exp_out      = fdiv(macc[gch]);
          phase        = 2;
        end
        default: if (out_ready) begin
          out_q.push_back(out_sample);
          phase = 0;
        end
      endcase
      for (int c = 0; c < NCH; c++)
        if (clr_v[c]) begin
          macc[c]    = 0;
          mprimed[c] = 1'b0;
        end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    last_gnt = strobe_seen;
    for (int c = 0; c < NCH; c++)
      if (strobe_seen[c]) begin
        vld[c] = 1'b0;
        if (auto_rearm) begin
          vld[c] = 1'b1;
          smp[c] = rnd_sample();
        end
      end
  endtask

  task automatic do_reset();
    rst = 1'b1; vld = '0; clr_v = '0; out_ready = 1'b0; auto_rearm = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    gnt_q.delete();
    out_q.delete();
  endtask

  task automatic wait_outs(input int n);
    int budget = 200;
    while (out_q.size() < n && budget > 0) begin tick(); budget--; end
    if (out_q.size() < n) check_eq("timeout_outs", out_q.size(), n);
  endtask

  task automatic wait_valid();
    int budget = 50;
    while (!out_valid && budget > 0) begin tick(); budget--; end
    if (!out_valid) check_eq("timeout_valid", out_valid, 1);
  endtask

  task automatic wait_grant(input int ch);
    int budget = 50;
    while (!last_gnt[ch] && budget > 0) begin tick(); budget--; end
    if (!last_gnt[ch]) check_eq("timeout_grant", last_gnt[ch], 1);
  endtask

  task automatic drain();
    vld = '0; clr_v = '0; out_ready = 1'b1; auto_rearm = 1'b0;
    repeat (6) tick();
  endtask

  localparam longint E800_1 = PRELOAD ? 800 : 100;
  localparam longint E800_2 = PRELOAD ? 800 : 187;

  initial begin
    for (int c = 0; c < NCH; c++) smp[c] = '0;

    do_reset();
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_sample", out_sample, 0);
    check_eq("rst_out_ch", out_ch, 0);
    check_eq("rst_req_ready", req_ready, 0);

    // Two 800 samples on channel 0.
    out_ready = 1'b1;
    vld[0] = 1'b1; smp[0] = 800;
    wait_outs(1);
    vld[0] = 1'b1; smp[0] = 800;
    wait_outs(2);
    if (out_q.size() >= 2) begin
      check_eq("ch0_first", out_q[0], E800_1);
      check_eq("ch0_second", out_q[1], E800_2);
    end
    drain();

    // All channels continuously requesting.
    do_reset();
    out_ready = 1'b1; auto_rearm = 1'b1;
    for (int c = 0; c < NCH; c++) begin vld[c] = 1'b1; smp[c] = rnd_sample(); end
    begin
      int budget = 100;
      while (gnt_q.size() < 5 && budget > 0) begin tick(); budget--; end
    end
    check_eq("rr_grants", gnt_q.size() >= 5 ? 1 : 0, 1);
    for (int i = 0; i < 5 && i < gnt_q.size(); i++) check_eq("rr_order", gnt_q[i], i % NCH);
    drain();

    // Stalled output holds steady and blocks grants.
    do_reset();
    vld[2] = 1'b1; smp[2] = 800;
    wait_valid();
    vld[1] = 1'b1; smp[1] = 400;
    for (int i = 0; i < 5; i++) begin
      check_eq("stall_valid", out_valid, 1);
      check_eq("stall_sample", out_sample, E800_1);
      check_eq("stall_ch", out_ch, 2);
      check_eq("stall_rdy", req_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check_eq("release_grant", req_ready, 4'b0010);
    wait_outs(2);
    if (out_q.size() >= 2) check_eq("release_ch1", out_q[1], PRELOAD ? 400 : 50);
    drain();

    // Clear during channel 1 update.
    do_reset();
    out_ready = 1'b1;
    vld[1] = 1'b1; smp[1] = 800;
    wait_grant(1);
    clr_v[1] = 1'b1;
    tick();
    clr_v[1] = 1'b0;
    wait_outs(1);
    vld[1] = 1'b1; smp[1] = 800;
    wait_outs(2);
    if (out_q.size() >= 2) begin
      check_eq("clr_first", out_q[0], E800_1);
      check_eq("clr_second", out_q[1], E800_1);
    end
    drain();

    // Reset in the middle of OUT.
    do_reset();
    vld[2] = 1'b1; smp[2] = 800;
    wait_valid();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("midrst_valid", out_valid, 0);
    gnt_q.delete();
    out_q.delete();
    vld[0] = 1'b1; smp[0] = -16'sd8;
    vld[2] = 1'b1; smp[2] = 800;
    out_ready = 1'b1;
    wait_outs(1);
    if (gnt_q.size() >= 1) check_eq("midrst_gnt", gnt_q[0], 0);
    if (out_q.size() >= 1) check_eq("midrst_neg", out_q[0], PRELOAD ? -8 : -1);
    drain();

    // Random traffic, clears, backpressure and occasional resets.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < NCH; c++) begin
        if (!vld[c] && $urandom_range(0, 1) == 1) begin
          vld[c] = 1'b1;
          smp[c] = rnd_sample();
        end
        clr_v[c] = ($urandom_range(0, 31) == 0);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 149) == 0);
      tick();
    end
    rst = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
